tx_rx_arbiter: RTL and testbench

Round-robin scheduler that shares the single TX→RX link between NREQ frame sources. It grants one requester at a time, streams a fixed BURST-word frame from that requester onto the link with a valid/ready handshake, and signals completion per requester. It sits between the frame producers and the TX datapath; BURST defaults to 4 words to match the 4-word RX RAM.

---
 rtl/tx_rx_arbiter.sv | 129 ++++++++++++
 tb/tb_tx_rx_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_rx_arbiter.sv
// Round-robin arbiter that streams fixed BURST-word frames from NREQ sources onto one valid/ready link.
// Optional stall timeout enabled by defining TX_RX_ARB_TIMEOUT_EN.
module tx_rx_arbiter #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int BURST = 4,
   parameter int TMO   = 64
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_pop,
   output logic [NREQ-1:0]      gnt,
   output logic                 tx_vld,
   output logic [DW-1:0]        tx_data,
   input  logic                 rx_ready,
   output logic [NREQ-1:0]      burst_done,
   output logic [NREQ-1:0]      burst_abort,
   output logic                 busy
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int GW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE, S_ABORT} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [GW-1:0]     r_ptr;
   logic [GW-1:0]     r_gidx;
   logic [GW-1:0]     w_pick;
   logic              w_any;
   logic [CW-1:0]     r_cnt;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   w_onehot;
   logic              w_hs;
   logic              w_last;
   logic              w_stall_hit;

   // First requesting source at or above r_ptr, wrapping; scanning downward lets the nearest win.
   always_comb begin
      w_any  = 1'b0;
      w_pick = r_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(r_ptr) + k) % NREQ]) begin
            w_any  = 1'b1;
            w_pick = GW'((int'(r_ptr) + k) % NREQ);
         end
      end
   end

   assign w_onehot = NREQ'(1) << r_gidx;
   assign w_hs     = (r_state == S_XFER) && rx_ready;
   assign w_last   = w_hs && (r_cnt == CW'(BURST - 1));

`ifdef TX_RX_ARB_TIMEOUT_EN
   localparam int SW = $clog2(TMO + 1);
   logic [SW-1:0] r_stall;

   assign w_stall_hit = (r_state == S_XFER) && !rx_ready && (r_stall == SW'(TMO - 1));

   always_ff @(posedge clk) begin
      if (clr) begin
         r_stall <= '0;
      end else if ((r_state != S_XFER) || w_hs) begin
         r_stall <= '0;
      end else begin
         r_stall <= r_stall + SW'(1);
      end
   end

   assign burst_abort = (r_state == S_ABORT) ? w_onehot : '0;
`else
   assign w_stall_hit = 1'b0;
   assign burst_abort = '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = S_XFER;
         S_XFER: begin
            if (w_last)           w_state_nxt = S_DONE;
            else if (w_stall_hit) w_state_nxt = S_ABORT;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ABORT: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_gidx  <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gidx <= w_pick;
                  r_gnt  <= NREQ'(1) << w_pick;
                  r_cnt  <= '0;
               end
            end
            S_XFER: begin
               if (w_hs) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
               if (w_state_nxt != S_XFER) r_gnt <= '0;
            end
            S_DONE, S_ABORT: begin
               r_ptr <= (r_gidx == GW'(NREQ - 1)) ? '0 : r_gidx + GW'(1);
            end
            default: ;
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign busy       = (r_state != S_IDLE);
   assign tx_vld     = (r_state == S_XFER);
   assign tx_data    = tx_vld ? req_data[r_gidx*DW +: DW] : '0;
   assign req_pop    = w_hs ? w_onehot : '0;
   assign burst_done = (r_state == S_DONE) ? w_onehot : '0;

endmodule

// File: tb/tb_tx_rx_arbiter.sv
// Self-checking bench for tx_rx_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_tx_rx_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int BURST = 4;
   localparam int TMO   = 64;
`ifdef TX_RX_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                clr = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*DW-1:0]  req_data = '0;
   logic [NREQ-1:0]     req_pop;
   logic [NREQ-1:0]     gnt;
   logic                tx_vld;
   logic [DW-1:0]       tx_data;
   logic                rx_ready = 1'b0;
   logic [NREQ-1:0]     burst_done;
   logic [NREQ-1:0]     burst_abort;
   logic                busy;

   tx_rx_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST), .TMO(TMO)) dut (
      .clk(clk), .clr(clr), .req(req), .req_data(req_data), .req_pop(req_pop),
      .gnt(gnt), .tx_vld(tx_vld), .tx_data(tx_data), .rx_ready(rx_ready),
      .burst_done(burst_done), .burst_abort(burst_abort), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Model: phase 0 idle, 1 transferring, 2 completion pulse, 3 abort pulse
   int m_phase = 0, m_g = 0, m_words = 0, m_ptr = 0, m_stall = 0;
   int src_idx [NREQ];
   logic [DW-1:0] base [NREQ];
   logic [NREQ-1:0] o_gnt, o_pop, o_done, o_abort;

   function automatic logic [DW-1:0] dval(input int i, input int k);
      return base[i] + DW'(k * 37);
   endfunction

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic cyc(input logic c, input logic [NREQ-1:0] r, input logic rdy, input bit do_chk);
      logic [NREQ-1:0] e_oh;
      int p;
      @(negedge clk);
      clr = c; req = r; rx_ready = rdy;
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dval(i, src_idx[i]);
      #1;
      o_gnt = gnt; o_pop = req_pop; o_done = burst_done; o_abort = burst_abort;
      e_oh = NREQ'(1) << m_g;
      if (do_chk) begin
         check_eq("busy", busy, m_phase != 0);
         check_eq("tx_vld", tx_vld, m_phase == 1);
         check_eq("tx_data", tx_data, (m_phase == 1) ? dval(m_g, src_idx[m_g]) : '0);
         check_eq("req_pop", req_pop, (m_phase == 1 && rdy) ? e_oh : '0);
         check_eq("burst_done", burst_done, (m_phase == 2) ? e_oh : '0);
         check_eq("burst_abort", burst_abort, (m_phase == 3) ? e_oh : '0);
         if (m_phase <= 1) check_eq("gnt", gnt, (m_phase == 1) ? e_oh : '0);
      end
      if (c) begin
         m_phase = 0; m_ptr = 0;
      end else begin
         case (m_phase)
            0: begin
               p = pick(r, m_ptr);
               if (p >= 0) begin m_g = p; m_words = 0; m_stall = 0; m_phase = 1; end
            end
            1: begin
               if (rdy) begin
                  src_idx[m_g]++; m_words++; m_stall = 0;
                  if (m_words == BURST) m_phase = 2;
               end else begin
                  m_stall++;
                  if (TO_EN && m_stall == TMO) m_phase = 3;
               end
            end
            default: begin m_ptr = (m_g + 1) % NREQ; m_phase = 0; end
         endcase
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && m_phase != 0; i++) cyc(1'b0, '0, 1'b1, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int npop, ndone, ab_at, ng;
      int order [5];
      logic [NREQ-1:0] seen [$];
      logic [NREQ-1:0] prev;
      logic [NREQ-1:0] rpat;
      for (int i = 0; i < NREQ; i++) begin src_idx[i] = 0; base[i] = DW'($urandom); end

      // Reset with all requests pending, then first grant goes to requester 0
      cyc(1'b1, '1, 1'b1, 1'b0);
      cyc(1'b1, '1, 1'b1, 1'b1);
      cyc(1'b0, '1, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      check_eq("gnt_after_reset", o_gnt, 4'b0001);
      drain();

      // Single burst from requester 2; completion pulse on the 6th cycle
      cyc(1'b1, '0, 1'b1, 1'b1);
      npop = 0;
      for (int i = 1; i <= 6; i++) begin
         cyc(1'b0, 4'b0100, 1'b1, 1'b1);
         if (o_pop == 4'b0100) npop++;
         if (i == 6) check_eq("single_done", o_done, 4'b0100);
      end
      check_eq("single_pops", npop, BURST);
      drain();

      // Round-robin with all requests held
      cyc(1'b1, '0, 1'b1, 1'b1);
      prev = '0;
      for (int i = 0; i < 5 * (BURST + 2); i++) begin
         cyc(1'b0, '1, 1'b1, 1'b1);
         if (o_gnt != 0 && prev == 0) seen.push_back(o_gnt);
         prev = o_gnt;
      end
      order = '{0, 1, 2, 3, 0};
      check_eq("rr_count", seen.size(), 5);
      for (int k = 0; k < 5 && k < seen.size(); k++)
         check_eq("rr_order", seen[k], NREQ'(1) << order[k]);
      drain();

      // Backpressure pattern 1,0,0,1,1,0,1
      cyc(1'b1, '0, 1'b1, 1'b1);
      cyc(1'b0, 4'b0001, 1'b1, 1'b1);
      rpat = '0; npop = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, '0, (7'b1011001 >> i) & 1'b1, 1'b1);
         if (o_pop != 0) npop++;
      end
      check_eq("bp_pops", npop, 4);
      cyc(1'b0, '0, 1'b1, 1'b1);
      check_eq("bp_done", o_done, 4'b0001);
      drain();

      // Stall after two words
      cyc(1'b1, '0, 1'b1, 1'b1);
      cyc(1'b0, 4'b0010, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
`ifdef TX_RX_ARB_TIMEOUT_EN
      ab_at = -1; ndone = 0;
      for (int i = 1; i <= 80; i++) begin
         cyc(1'b0, '0, 1'b0, 1'b1);
         if (o_done != 0) ndone++;
         if (o_abort != 0) begin
            check_eq("abort_vec", o_abort, 4'b0010);
            ab_at = i;
            break;
         end
      end
      check_eq("abort_cycle", ab_at, TMO + 1);
      check_eq("abort_no_done", ndone, 0);
      cyc(1'b0, '1, 1'b1, 1'b1);
      cyc(1'b0, '1, 1'b1, 1'b1);
      check_eq("after_abort_gnt", o_gnt, 4'b0100);
`else
      for (int i = 0; i < 200; i++) cyc(1'b0, '0, 1'b0, 1'b1);
      check_eq("hold_gnt", o_gnt, 4'b0010);
      check_eq("hold_busy", busy, 1'b1);
`endif
      drain();

      // Reset in the middle of a burst
      cyc(1'b1, '0, 1'b1, 1'b1);
      cyc(1'b0, 4'b1000, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b1, '0, 1'b1, 1'b1);
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b1);
         if (o_done != 0 || o_abort != 0) ndone++;
      end
      check_eq("midreset_pulses", ndone, 0);
      cyc(1'b0, '1, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      check_eq("midreset_ptr", o_gnt, 4'b0001);
      drain();

      // Randomized traffic, backpressure and occasional reset
      for (int i = 0; i < 2000; i++) begin
         for (int b = 0; b < NREQ; b++) rpat[b] = ($urandom_range(0, 9) < 3);
         cyc(($urandom_range(0, 199) == 0), rpat, ($urandom_range(0, 9) < 7), 1'b1);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
